// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result pipeline.
// NZCV bit positions, the flag bundle and the pipeline-occupancy state.
package alu_pkg;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  localparam int ALU_DEFAULT_WIDTH     = 8;
  localparam int ALU_DEFAULT_NUM_UNITS = 16;
  localparam int ALU_DEFAULT_SEL_W     = 4;

  // Field order matches the NZCV bit positions, so the struct can be
  // copied straight into the status register.
  typedef struct packed {
    logic neg;
    logic zero;
    logic cout;
    logic ovf;
  } alu_flags_t;

  typedef enum logic {
    PIPE_EMPTY = 1'b0,
    PIPE_FULL  = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/alu_unit_select.sv
// Combinational selection of one functional-unit result and its flags.
// An out-of-range select yields a zero result with only zero/sel_err set.
module alu_unit_select
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_DEFAULT_WIDTH,
  parameter int NUM_UNITS = ALU_DEFAULT_NUM_UNITS,
  parameter int SEL_W     = ALU_DEFAULT_SEL_W
) (
  input  logic [SEL_W-1:0]           sel_i,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result_i,
  input  logic [NUM_UNITS-1:0]       unit_ovf_i,
  input  logic [NUM_UNITS-1:0]       unit_cout_i,
  output logic [WIDTH-1:0]           result_o,
  output alu_flags_t                 flags_o,
  output logic                       sel_err_o
);

  logic ovf;
  logic cout;

  // Compare against each unit index instead of indexing by sel, so an
  // illegal select never reads past the packed bus.
  always_comb begin
    result_o  = '0;
    ovf       = 1'b0;
    cout      = 1'b0;
    sel_err_o = 1'b1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_i == SEL_W'(i)) begin
        result_o  = unit_result_i[i*WIDTH +: WIDTH];
        ovf       = unit_ovf_i[i];
        cout      = unit_cout_i[i];
        sel_err_o = 1'b0;
      end
    end
  end

  always_comb begin
    flags_o      = '0;
    flags_o.neg  = result_o[WIDTH-1];
    flags_o.zero = ~|result_o;
    flags_o.cout = cout;
    flags_o.ovf  = ovf;
  end

endmodule

// File: rtl/alu_result_pipe.sv
// Registered ALU output selector with valid/ready handshake and NZCV register.
// Optional sticky overflow flag when ALU_STICKY_OVF_EN is defined.
module alu_result_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_DEFAULT_WIDTH,
  parameter int NUM_UNITS = ALU_DEFAULT_NUM_UNITS,
  parameter int SEL_W     = ALU_DEFAULT_SEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       upd_flags,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]       unit_ovf,
  input  logic [NUM_UNITS-1:0]       unit_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       overflow,
  output logic                       cout,
  output logic                       negativo,
  output logic                       zero,
  output logic                       sel_err,
  output logic [3:0]                 nzcv
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic                       sticky_clr,
  output logic                       sticky_ovf
`endif
);

  if (NUM_UNITS < 1 || (2 ** SEL_W) < NUM_UNITS) begin : g_bad_cfg
    $error("alu_result_pipe: NUM_UNITS must be in 1..2**SEL_W");
  end

  logic [WIDTH-1:0] sel_result;
  alu_flags_t       sel_flags;
  logic             sel_illegal;

  alu_unit_select #(
    .WIDTH    (WIDTH),
    .NUM_UNITS(NUM_UNITS),
    .SEL_W    (SEL_W)
  ) u_select (
    .sel_i        (sel),
    .unit_result_i(unit_result),
    .unit_ovf_i   (unit_ovf),
    .unit_cout_i  (unit_cout),
    .result_o     (sel_result),
    .flags_o      (sel_flags),
    .sel_err_o    (sel_illegal)
  );

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             sel_err_q, sel_err_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic             accept;
  logic             drain;

  assign out_valid = (state_q == PIPE_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Data registers load only on accept, so a plain drain leaves them holding.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    sel_err_d = sel_err_q;
    nzcv_d    = nzcv_q;
    if (accept) begin
      state_d   = PIPE_FULL;
      result_d  = sel_result;
      flags_d   = sel_flags;
      sel_err_d = sel_illegal;
      if (upd_flags && !sel_illegal) begin
        nzcv_d = sel_flags;
      end
    end else if (drain) begin
      state_d = PIPE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PIPE_EMPTY;
      result_q  <= '0;
      flags_q   <= '0;
      sel_err_q <= 1'b0;
      nzcv_q    <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      sel_err_q <= sel_err_d;
      nzcv_q    <= nzcv_d;
    end
  end

  assign result   = result_q;
  assign negativo = flags_q.neg;
  assign zero     = flags_q.zero;
  assign cout     = flags_q.cout;
  assign overflow = flags_q.ovf;
  assign sel_err  = sel_err_q;
  assign nzcv     = nzcv_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set is applied after clear so a same-cycle overflow wins.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end
    if (accept && !sel_illegal && sel_flags.ovf) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_pipe.sv
// Self-checking bench for alu_result_pipe (WIDTH=8, NUM_UNITS=12, SEL_W=4).
// Directed table, multi-cycle sequences and a randomized reference model.
module tb_alu_result_pipe;

  localparam int W  = 8;
  localparam int NU = 12;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic          upd_flags;
  logic [NU*W-1:0] unit_result;
  logic [NU-1:0] unit_ovf;
  logic [NU-1:0] unit_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          overflow;
  logic          cout;
  logic          negativo;
  logic          zero;
  logic          sel_err;
  logic [3:0]    nzcv;
  logic          sticky_clr;
  logic          sticky_ovf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] units[NU];

  always #5 clk = ~clk;

  alu_result_pipe #(
    .WIDTH    (W),
    .NUM_UNITS(NU),
    .SEL_W    (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .upd_flags  (upd_flags),
    .unit_result(unit_result),
    .unit_ovf   (unit_ovf),
    .unit_cout  (unit_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .cout       (cout),
    .negativo   (negativo),
    .zero       (zero),
    .sel_err    (sel_err),
    .nzcv       (nzcv)
`ifdef ALU_STICKY_OVF_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf)
`endif
  );

`ifndef ALU_STICKY_OVF_EN
  assign sticky_ovf = 1'b0;
`endif

  typedef struct {
    logic [3:0] sel;
    logic       upd;
    logic [7:0] val;
    logic       ovf;
    logic       cy;
    logic [7:0] eRes;
    logic       eN;
    logic       eZ;
    logic       eC;
    logic       eV;
    logic       eErr;
    logic [3:0] eNzcv;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic packUnits();
    for (int i = 0; i < NU; i++) unit_result[i*W +: W] = units[i];
  endtask

  // Drive one request at the negedge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [3:0] s, input logic upd, input logic [7:0] val,
                               input logic ovf, input logic cy);
    @(negedge clk);
    for (int i = 0; i < NU; i++) units[i] = 8'($urandom);
    unit_ovf  = NU'($urandom);
    unit_cout = NU'($urandom);
    if (s < NU) begin
      units[s]     = val;
      unit_ovf[s]  = ovf;
      unit_cout[s] = cy;
    end else begin
      unit_ovf  = '1;
      unit_cout = '1;
    end
    packUnits();
    sel       = s;
    upd_flags = upd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  logic       mValid;
  logic [7:0] mRes;
  logic       mN, mZ, mC, mV, mErr, mSticky;
  logic [3:0] mNzcv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; upd_flags = 1'b0;
    unit_result = '0; unit_ovf = '0; unit_cout = '0; sticky_clr = 1'b0;

    vecs[0] = '{4'd3,  1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011};
    vecs[1] = '{4'd5,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011};
    vecs[2] = '{4'd13, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011};
    vecs[3] = '{4'd11, 1'b1, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[4] = '{4'd0,  1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101};
    vecs[5] = '{4'd12, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101};
    vecs[6] = '{4'd15, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101};
    vecs[7] = '{4'd7,  1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result",    32'(result),    32'd0);
    checkOutput("rst_zero",      32'(zero),      32'd0);
    checkOutput("rst_sel_err",   32'(sel_err),   32'd0);
    checkOutput("rst_nzcv",      32'(nzcv),      32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].sel, vecs[k].upd, vecs[k].val, vecs[k].ovf, vecs[k].cy);
      checkOutput($sformatf("vec%0d_valid", k),    32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_result", k),   32'(result),    32'(vecs[k].eRes));
      checkOutput($sformatf("vec%0d_flags", k),
                  32'({negativo, zero, cout, overflow}),
                  32'({vecs[k].eN, vecs[k].eZ, vecs[k].eC, vecs[k].eV}));
      checkOutput($sformatf("vec%0d_sel_err", k),  32'(sel_err),   32'(vecs[k].eErr));
      checkOutput($sformatf("vec%0d_nzcv", k),     32'(nzcv),      32'(vecs[k].eNzcv));
    end

    // Back-to-back: four requests on consecutive edges, then a 3-cycle stall.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checkOutput($sformatf("b2b%0d_valid", k - 1),  32'(out_valid), 32'd1);
        checkOutput($sformatf("b2b%0d_result", k - 1), 32'(result),    32'(8'h81 + k - 1));
      end
      for (int i = 0; i < NU; i++) units[i] = 8'h00;
      units[k] = 8'(8'h81 + k);
      packUnits();
      unit_ovf = '0; unit_cout = '0;
      sel = SW'(k); upd_flags = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("b2b3_result", 32'(result), 32'h84);
    checkOutput("b2b3_nzcv",   32'(nzcv),   32'b1000);
    units[0] = 8'h55; packUnits(); sel = '0; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", k),  32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d_result", k), 32'(result),    32'h84);
    end

    // Reset while a result is held.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("midrst_valid",    32'(out_valid), 32'd0);
    checkOutput("midrst_nzcv",     32'(nzcv),      32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready),  32'd1);

`ifdef ALU_STICKY_OVF_EN
    applyStimulus(4'd2, 1'b0, 8'h10, 1'b1, 1'b0);
    checkOutput("sticky_set", 32'(sticky_ovf), 32'd1);
    applyStimulus(4'd3, 1'b0, 8'h11, 1'b0, 1'b0);
    checkOutput("sticky_hold1", 32'(sticky_ovf), 32'd1);
    applyStimulus(4'd4, 1'b1, 8'h12, 1'b0, 1'b0);
    checkOutput("sticky_hold2", 32'(sticky_ovf), 32'd1);
    @(negedge clk);
    sticky_clr = 1'b1;
    applyStimulus(4'd1, 1'b0, 8'h13, 1'b1, 1'b0);
    sticky_clr = 1'b0;
    checkOutput("sticky_clr_vs_set", 32'(sticky_ovf), 32'd1);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    checkOutput("sticky_clr", 32'(sticky_ovf), 32'd0);
`endif

    // Randomized traffic against the reference model.
    doReset();
    mValid = 1'b0; mRes = '0; mN = 0; mZ = 0; mC = 0; mV = 0; mErr = 0; mNzcv = '0; mSticky = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic acc, expReady;
      @(negedge clk);
      checkOutput("rnd_valid",  32'(out_valid), 32'(mValid));
      checkOutput("rnd_result", 32'(result),    32'(mRes));
      checkOutput("rnd_flags",  32'({negativo, zero, cout, overflow, sel_err}),
                  32'({mN, mZ, mC, mV, mErr}));
      checkOutput("rnd_nzcv",   32'(nzcv),      32'(mNzcv));
`ifdef ALU_STICKY_OVF_EN
      checkOutput("rnd_sticky", 32'(sticky_ovf), 32'(mSticky));
`endif
      for (int i = 0; i < NU; i++) units[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      packUnits();
      unit_ovf   = NU'($urandom);
      unit_cout  = NU'($urandom);
      sel        = SW'($urandom_range(0, 15));
      upd_flags  = 1'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      #1;
      expReady = !mValid || out_ready;
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(expReady));
      acc = in_valid && expReady;
      if (sticky_clr) mSticky = 1'b0;
      if (acc) begin
        if (int'(sel) < NU) begin
          mRes = units[sel];
          mV   = unit_ovf[sel];
          mC   = unit_cout[sel];
          mErr = 1'b0;
          if (mV) mSticky = 1'b1;
        end else begin
          mRes = 8'h00; mV = 1'b0; mC = 1'b0; mErr = 1'b1;
        end
        mN = (mRes >= 8'h80);
        mZ = (mRes == 8'h00);
        if (upd_flags && !mErr) mNzcv = {mN, mZ, mC, mV};
        mValid = 1'b1;
      end else if (mValid && out_ready) begin
        mValid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
